// File: rtl/oc8051_irq_ctrl.sv
// oc8051 interrupt controller: IE/IP/TCON[3:0], two-level priority with
// a service stack, vector request/acknowledge to the core.
//
// Ports:
//   clk, rst           clock; asynchronous active-high reset
//   wr_addr, data_in   SFR write address (byte or bit) and data
//   wr, wr_bit         write strobe; bit-addressed write select
//   rd_addr, data_out  SFR read address; registered read data
//   int0_n, int1_n     external interrupt pins, active low
//   tf0, tf1, ri, ti   timer and UART flags (levels)
//   int_ack, reti      core accept / return-from-interrupt pulses
//   irq, int_vec       request and vector to the core
//   tf0_clr, tf1_clr   one-cycle clear pulses to the timer block
// Build option OC8051_IRQ_TF2_EN adds the TF2 source (tf2 in,
// tf2_clr out, vector 0x2B).

module oc8051_irq_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] wr_addr,
  input  logic [7:0] rd_addr,
  input  logic [7:0] data_in,
  input  logic       wr,
  input  logic       wr_bit,
  input  logic       int0_n,
  input  logic       int1_n,
  input  logic       tf0,
  input  logic       tf1,
  input  logic       ri,
  input  logic       ti,
`ifdef OC8051_IRQ_TF2_EN
  input  logic       tf2,
  output logic       tf2_clr,
`endif
  input  logic       int_ack,
  input  logic       reti,
  output logic       irq,
  output logic [7:0] int_vec,
  output logic       tf0_clr,
  output logic       tf1_clr,
  output logic [7:0] data_out
);

  localparam logic [7:0] A_TCON = 8'h88;
  localparam logic [7:0] A_IE   = 8'hA8;
  localparam logic [7:0] A_IP   = 8'hB8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;

  logic [7:0] ie_q, ie_d;
  logic [7:0] ip_q, ip_d;
  logic [3:0] tcon_q, tcon_d, tcon_w;
  logic [1:0] in_svc_q, in_svc_d, svc_pop;
  logic [1:0] state_q, state_d;
  logic [7:0] vec_q, vec_d;
  logic [2:0] src_q, src_d;
  logic       lvl_q, lvl_d;
  logic       tf0_clr_q, tf0_clr_d;
  logic       tf1_clr_q, tf1_clr_d;
  logic [7:0] dout_q, dout_d;
  logic       int0_s_q, int0_p_q;
  logic       int1_s_q, int1_p_q;

  logic       byte_wr, bit_wr;
  logic       fall0, fall1;
  logic       ack_go;
  logic [5:0] flags, pend, hi, lo;
  logic       any;
  logic [2:0] sel_src;
  logic       sel_lvl;
  logic [7:0] sel_vec;

  assign byte_wr = wr & ~wr_bit;
  assign bit_wr  = wr &  wr_bit;

  assign fall0 = int0_p_q & ~int0_s_q;
  assign fall1 = int1_p_q & ~int1_s_q;

  assign ack_go = (state_q == S_REQ) & int_ack;

  // SFR writes; TCON value before hardware flag updates
  always_comb begin
    ie_d   = ie_q;
    ip_d   = ip_q;
    tcon_w = tcon_q;
    if (byte_wr) begin
      if (wr_addr == A_IE)   ie_d   = data_in;
      if (wr_addr == A_IP)   ip_d   = data_in;
      if (wr_addr == A_TCON) tcon_w = data_in[3:0];
    end
    if (bit_wr) begin
      if (wr_addr[7:3] == A_IE[7:3])
        ie_d[wr_addr[2:0]] = data_in[0];
      if (wr_addr[7:3] == A_IP[7:3])
        ip_d[wr_addr[2:0]] = data_in[0];
      if (wr_addr[7:2] == A_TCON[7:2])
        tcon_w[wr_addr[1:0]] = data_in[0];
    end
  end

  // IE0/IE1: level mode tracks the pin; edge mode latches a
  // falling edge, which wins over a software or ack clear
  always_comb begin
    tcon_d = tcon_w;
    if (!tcon_q[0])
      tcon_d[1] = ~int0_s_q;
    else if (fall0)
      tcon_d[1] = 1'b1;
    else if (ack_go && src_q == 3'd0)
      tcon_d[1] = 1'b0;
    if (!tcon_q[2])
      tcon_d[3] = ~int1_s_q;
    else if (fall1)
      tcon_d[3] = 1'b1;
    else if (ack_go && src_q == 3'd2)
      tcon_d[3] = 1'b0;
  end

`ifdef OC8051_IRQ_TF2_EN
  assign flags = {tf2, ri | ti, tf1, tcon_q[3], tf0, tcon_q[1]};
  assign tf2_clr = 1'b0;
`else
  assign flags = {1'b0, ri | ti, tf1, tcon_q[3], tf0, tcon_q[1]};
`endif

  assign pend = flags & ie_q[5:0] & {6{ie_q[7]}};
  assign hi = pend & ip_q[5:0] & {6{~in_svc_q[1]}};
  assign lo = pend & ~ip_q[5:0] & {6{in_svc_q == 2'b00}};

  function automatic logic [2:0] first_set(input logic [5:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 5; i >= 0; i--)
      if (v[i]) r = 3'(i);
    return r;
  endfunction

  assign any     = (|hi) | (|lo);
  assign sel_lvl = |hi;
  assign sel_src = sel_lvl ? first_set(hi) : first_set(lo);
  assign sel_vec = {2'b00, sel_src, 3'b011};

  // reti pops before an ack in the same cycle pushes
  always_comb begin
    svc_pop = in_svc_q;
    if (reti)
      svc_pop = in_svc_q[1] ? {1'b0, in_svc_q[0]} : 2'b00;
    in_svc_d = svc_pop;
    if (ack_go)
      in_svc_d[lvl_q] = 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    src_d     = src_q;
    lvl_d     = lvl_q;
    tf0_clr_d = 1'b0;
    tf1_clr_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (any) begin
          state_d = S_REQ;
          vec_d   = sel_vec;
          src_d   = sel_src;
          lvl_d   = sel_lvl;
        end
      end
      S_REQ: begin
        if (int_ack) begin
          state_d   = S_ACK;
          tf0_clr_d = (src_q == 3'd1);
          tf1_clr_d = (src_q == 3'd3);
        end else if (any) begin
          vec_d = sel_vec;
          src_d = sel_src;
          lvl_d = sel_lvl;
        end else begin
          state_d = S_IDLE;
          vec_d   = 8'h00;
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
        vec_d   = 8'h00;
      end
      default: begin
        state_d = S_IDLE;
        vec_d   = 8'h00;
      end
    endcase
  end

  // Read path; a same-cycle byte write is forwarded
  always_comb begin
    dout_d = 8'h00;
    case (rd_addr)
      A_IE:    dout_d = ie_q;
      A_IP:    dout_d = ip_q;
      A_TCON:  dout_d = {4'b0000, tcon_q};
      default: dout_d = 8'h00;
    endcase
    if (byte_wr && wr_addr == rd_addr) begin
      case (rd_addr)
        A_IE:    dout_d = data_in;
        A_IP:    dout_d = data_in;
        A_TCON:  dout_d = {4'b0000, data_in[3:0]};
        default: dout_d = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ie_q      <= 8'h00;
      ip_q      <= 8'h00;
      tcon_q    <= 4'h0;
      in_svc_q  <= 2'b00;
      state_q   <= S_IDLE;
      vec_q     <= 8'h00;
      src_q     <= 3'd0;
      lvl_q     <= 1'b0;
      tf0_clr_q <= 1'b0;
      tf1_clr_q <= 1'b0;
      dout_q    <= 8'h00;
      int0_s_q  <= 1'b1;
      int0_p_q  <= 1'b1;
      int1_s_q  <= 1'b1;
      int1_p_q  <= 1'b1;
    end else begin
      ie_q      <= ie_d;
      ip_q      <= ip_d;
      tcon_q    <= tcon_d;
      in_svc_q  <= in_svc_d;
      state_q   <= state_d;
      vec_q     <= vec_d;
      src_q     <= src_d;
      lvl_q     <= lvl_d;
      tf0_clr_q <= tf0_clr_d;
      tf1_clr_q <= tf1_clr_d;
      dout_q    <= dout_d;
      int0_s_q  <= int0_n;
      int0_p_q  <= int0_s_q;
      int1_s_q  <= int1_n;
      int1_p_q  <= int1_s_q;
    end
  end

  assign irq      = (state_q == S_REQ);
  assign int_vec  = vec_q;
  assign tf0_clr  = tf0_clr_q;
  assign tf1_clr  = tf1_clr_q;
  assign data_out = dout_q;

endmodule

// File: tb/tb_oc8051_irq_ctrl.sv
// Directed bench for oc8051_irq_ctrl.
// Timer/core behaviour is emulated by hand in each scenario task.

module tb_oc8051_irq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] wr_addr, rd_addr, data_in;
  logic       wr, wr_bit;
  logic       int0_n, int1_n;
  logic       tf0, tf1, ri, ti;
`ifdef OC8051_IRQ_TF2_EN
  logic       tf2;
  logic       tf2_clr;
`endif
  logic       int_ack, reti;
  logic       irq;
  logic [7:0] int_vec;
  logic       tf0_clr, tf1_clr;
  logic [7:0] data_out;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  oc8051_irq_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .wr_addr  (wr_addr),
    .rd_addr  (rd_addr),
    .data_in  (data_in),
    .wr       (wr),
    .wr_bit   (wr_bit),
    .int0_n   (int0_n),
    .int1_n   (int1_n),
    .tf0      (tf0),
    .tf1      (tf1),
    .ri       (ri),
    .ti       (ti),
`ifdef OC8051_IRQ_TF2_EN
    .tf2      (tf2),
    .tf2_clr  (tf2_clr),
`endif
    .int_ack  (int_ack),
    .reti     (reti),
    .irq      (irq),
    .int_vec  (int_vec),
    .tf0_clr  (tf0_clr),
    .tf1_clr  (tf1_clr),
    .data_out (data_out)
  );

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sfr_wr(input logic [7:0] a, input logic [7:0] d);
    wr_addr = a; data_in = d; wr = 1'b1; wr_bit = 1'b0;
    tick();
    wr = 1'b0;
  endtask

  task automatic bit_wr(input logic [7:0] a, input logic b);
    wr_addr = a; data_in = {7'b0, b}; wr = 1'b1; wr_bit = 1'b1;
    tick();
    wr = 1'b0; wr_bit = 1'b0;
  endtask

  task automatic pulse_ack();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
  endtask

  task automatic pulse_reti();
    reti = 1'b1;
    tick();
    reti = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wr_addr = 8'h00; rd_addr = 8'hA8; data_in = 8'h00;
    wr = 1'b0; wr_bit = 1'b0;
    int0_n = 1'b1; int1_n = 1'b1;
    tf0 = 1'b0; tf1 = 1'b0; ri = 1'b0; ti = 1'b0;
`ifdef OC8051_IRQ_TF2_EN
    tf2 = 1'b0;
`endif
    int_ack = 1'b0; reti = 1'b0;
    #12;
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL rst_irq got=%b exp=0", irq); end
    n_cmp++; if (int_vec !== 8'h00) begin n_err++; $display("FAIL rst_vec got=%h exp=00", int_vec); end
    n_cmp++; if (tf0_clr !== 1'b0) begin n_err++; $display("FAIL rst_tf0clr got=%b exp=0", tf0_clr); end
    n_cmp++; if (tf1_clr !== 1'b0) begin n_err++; $display("FAIL rst_tf1clr got=%b exp=0", tf1_clr); end
    n_cmp++; if (data_out !== 8'h00) begin n_err++; $display("FAIL rst_dout got=%h exp=00", data_out); end
    rst = 1'b0;
    rd_addr = 8'h88;
    tick(2);
    n_cmp++; if (data_out !== 8'h00) begin n_err++; $display("FAIL rst_tcon got=%h exp=00", data_out); end
  endtask

  task automatic test_tf0();
    sfr_wr(8'hA8, 8'h82);
    tf0 = 1'b1;
    tick();
    n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL tf0_irq got=%b exp=1", irq); end
    n_cmp++; if (int_vec !== 8'h0B) begin n_err++; $display("FAIL tf0_vec got=%h exp=0b", int_vec); end
    pulse_ack();
    n_cmp++; if (tf0_clr !== 1'b1) begin n_err++; $display("FAIL tf0_clr got=%b exp=1", tf0_clr); end
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL tf0_ackirq got=%b exp=0", irq); end
    tf0 = 1'b0;
    tick();
    n_cmp++; if (tf0_clr !== 1'b0) begin n_err++; $display("FAIL tf0_clr_len got=%b exp=0", tf0_clr); end
    // low level in service: another low source must wait
    sfr_wr(8'hA8, 8'h8A);
    tf1 = 1'b1;
    tick(2);
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL tf0_svc_block got=%b exp=0", irq); end
    pulse_reti();
    tick();
    n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL tf1_after_reti got=%b exp=1", irq); end
    n_cmp++; if (int_vec !== 8'h1B) begin n_err++; $display("FAIL tf1_vec got=%h exp=1b", int_vec); end
    pulse_ack();
    n_cmp++; if (tf1_clr !== 1'b1) begin n_err++; $display("FAIL tf1_clr got=%b exp=1", tf1_clr); end
    tf1 = 1'b0;
    tick();
    pulse_reti();
    sfr_wr(8'hA8, 8'h00);
  endtask

  task automatic test_ext0_edge();
    rd_addr = 8'h88;
    bit_wr(8'h88, 1'b1);
    sfr_wr(8'hA8, 8'h81);
    int0_n = 1'b0;
    tick();
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL ex0_clk1 got=%b exp=0", irq); end
    tick();
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL ex0_clk2 got=%b exp=0", irq); end
    tick();
    n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL ex0_clk3 got=%b exp=1", irq); end
    n_cmp++; if (int_vec !== 8'h03) begin n_err++; $display("FAIL ex0_vec got=%h exp=03", int_vec); end
    n_cmp++; if (data_out !== 8'h03) begin n_err++; $display("FAIL ex0_tcon got=%h exp=03", data_out); end
    pulse_ack();
    n_cmp++; if (tf0_clr !== 1'b0) begin n_err++; $display("FAIL ex0_notf0clr got=%b exp=0", tf0_clr); end
    tick();
    n_cmp++; if (data_out !== 8'h01) begin n_err++; $display("FAIL ex0_ackclr got=%h exp=01", data_out); end
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL ex0_idle got=%b exp=0", irq); end
    pulse_reti();
    // level mode: IE0 follows the pin and survives the ack
    bit_wr(8'h88, 1'b0);
    tick(2);
    n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL ex0l_irq got=%b exp=1", irq); end
    n_cmp++; if (int_vec !== 8'h03) begin n_err++; $display("FAIL ex0l_vec got=%h exp=03", int_vec); end
    pulse_ack();
    tick();
    n_cmp++; if (data_out !== 8'h02) begin n_err++; $display("FAIL ex0l_keep got=%h exp=02", data_out); end
    int0_n = 1'b1;
    sfr_wr(8'hA8, 8'h00);
    tick();
    pulse_reti();
    tick(2);
  endtask

  task automatic test_preempt();
    sfr_wr(8'hA8, 8'h8A);
    tf0 = 1'b1;
    tick();
    n_cmp++; if (int_vec !== 8'h0B) begin n_err++; $display("FAIL pre_low_vec got=%h exp=0b", int_vec); end
    pulse_ack();
    n_cmp++; if (tf0_clr !== 1'b1) begin n_err++; $display("FAIL pre_tf0clr got=%b exp=1", tf0_clr); end
    tf0 = 1'b0;
    tick();
    sfr_wr(8'hB8, 8'h08);
    tf1 = 1'b1;
    tf0 = 1'b1;
    tick();
    n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL pre_hi_irq got=%b exp=1", irq); end
    n_cmp++; if (int_vec !== 8'h1B) begin n_err++; $display("FAIL pre_hi_vec got=%h exp=1b", int_vec); end
    pulse_ack();
    n_cmp++; if (tf1_clr !== 1'b1) begin n_err++; $display("FAIL pre_tf1clr got=%b exp=1", tf1_clr); end
    tf1 = 1'b0;
    tick(2);
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL pre_nest_hold got=%b exp=0", irq); end
    pulse_reti();
    tick();
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL pre_one_reti got=%b exp=0", irq); end
    pulse_reti();
    tick();
    n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL pre_two_reti got=%b exp=1", irq); end
    n_cmp++; if (int_vec !== 8'h0B) begin n_err++; $display("FAIL pre_low2_vec got=%h exp=0b", int_vec); end
    pulse_ack();
    tf0 = 1'b0;
    tick();
    pulse_reti();
    sfr_wr(8'hA8, 8'h00);
    sfr_wr(8'hB8, 8'h00);
  endtask

  task automatic test_same_cycle();
    sfr_wr(8'hB8, 8'h04);
    sfr_wr(8'hA8, 8'h8E);
    tf0 = 1'b1;
    int1_n = 1'b0;
    tick();
    n_cmp++; if (int_vec !== 8'h0B) begin n_err++; $display("FAIL sc_first got=%h exp=0b", int_vec); end
    tick(2);
    n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL sc_irq got=%b exp=1", irq); end
    n_cmp++; if (int_vec !== 8'h13) begin n_err++; $display("FAIL sc_replace got=%h exp=13", int_vec); end
    pulse_ack();
    n_cmp++; if (tf0_clr !== 1'b0) begin n_err++; $display("FAIL sc_notf0clr got=%b exp=0", tf0_clr); end
    int1_n = 1'b1;
    tick(3);
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL sc_hold got=%b exp=0", irq); end
    pulse_reti();
    tick();
    n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL sc_second got=%b exp=1", irq); end
    n_cmp++; if (int_vec !== 8'h0B) begin n_err++; $display("FAIL sc_vec2 got=%h exp=0b", int_vec); end
    pulse_ack();
    n_cmp++; if (tf0_clr !== 1'b1) begin n_err++; $display("FAIL sc_tf0clr got=%b exp=1", tf0_clr); end
    tf0 = 1'b0;
    tick();
    pulse_reti();
    sfr_wr(8'hA8, 8'h00);
    sfr_wr(8'hB8, 8'h00);
  endtask

  task automatic test_sfr_rw();
    rd_addr = 8'h88;
    sfr_wr(8'h88, 8'h05);
    n_cmp++; if (data_out !== 8'h05) begin n_err++; $display("FAIL tcon_fwd got=%h exp=05", data_out); end
    tick();
    n_cmp++; if (data_out !== 8'h05) begin n_err++; $display("FAIL tcon_reg got=%h exp=05", data_out); end
    sfr_wr(8'h88, 8'hF0);
    n_cmp++; if (data_out !== 8'h00) begin n_err++; $display("FAIL tcon_mask got=%h exp=00", data_out); end
    rd_addr = 8'hB8;
    sfr_wr(8'hB8, 8'h15);
    n_cmp++; if (data_out !== 8'h15) begin n_err++; $display("FAIL ip_fwd got=%h exp=15", data_out); end
    bit_wr(8'hB9, 1'b1);
    tick();
    n_cmp++; if (data_out !== 8'h17) begin n_err++; $display("FAIL ip_bit got=%h exp=17", data_out); end
    sfr_wr(8'hB8, 8'h00);
    sfr_wr(8'hA8, 8'h82);
    tf0 = 1'b1;
    tick();
    n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL ea_pre got=%b exp=1", irq); end
    bit_wr(8'hAF, 1'b0);
    n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL ea_same got=%b exp=1", irq); end
    tick();
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL ea_drop got=%b exp=0", irq); end
    rd_addr = 8'hA8;
    tick();
    n_cmp++; if (data_out !== 8'h02) begin n_err++; $display("FAIL ie_read got=%h exp=02", data_out); end
    tf0 = 1'b0;
    sfr_wr(8'hA8, 8'h00);
  endtask

  task automatic test_tf2();
    sfr_wr(8'hA8, 8'hA0);
`ifdef OC8051_IRQ_TF2_EN
    tf2 = 1'b1;
    tick();
    n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL tf2_irq got=%b exp=1", irq); end
    n_cmp++; if (int_vec !== 8'h2B) begin n_err++; $display("FAIL tf2_vec got=%h exp=2b", int_vec); end
    pulse_ack();
    n_cmp++; if (tf2_clr !== 1'b0) begin n_err++; $display("FAIL tf2_noclr got=%b exp=0", tf2_clr); end
    tf2 = 1'b0;
    tick();
    pulse_reti();
`else
    tick(3);
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL tf2_off got=%b exp=0", irq); end
`endif
    rd_addr = 8'hA8;
    tick();
    n_cmp++; if (data_out !== 8'hA0) begin n_err++; $display("FAIL ie5_read got=%h exp=a0", data_out); end
    sfr_wr(8'hA8, 8'h00);
  endtask

  task automatic test_reset_mid();
    sfr_wr(8'hA8, 8'h82);
    tf0 = 1'b1;
    tick();
    pulse_ack();
    tick();
    sfr_wr(8'hB8, 8'h02);
    tick();
    n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL mid_hi got=%b exp=1", irq); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL mid_irq got=%b exp=0", irq); end
    n_cmp++; if (int_vec !== 8'h00) begin n_err++; $display("FAIL mid_vec got=%h exp=00", int_vec); end
    #2 rst = 1'b0;
    sfr_wr(8'hA8, 8'h82);
    tick();
    n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL mid_svc_gone got=%b exp=1", irq); end
    n_cmp++; if (int_vec !== 8'h0B) begin n_err++; $display("FAIL mid_vec2 got=%h exp=0b", int_vec); end
    tf0 = 1'b0;
    sfr_wr(8'hA8, 8'h00);
    tick();
  endtask

  initial begin
    test_reset();
    test_tf0();
    test_ext0_edge();
    test_preempt();
    test_same_cycle();
    test_sfr_rw();
    test_tf2();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
